// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush controller.
// Two-state FSM (StRun, StMemWait) with Mealy control outputs. Priority is
// memory stall > branch flush > load-use stall. A 16-bit wait counter drives a
// sticky mem_timeout flag. Optional performance counters are built only when
// the STALL_PERF_CNT_EN macro is defined; otherwise the count outputs are 0.
module pipeline_stall_controller #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_Detected,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             freeze_IF,
  output logic             flush_IF,
  output logic             flush_ID,
  output logic             freeze_all,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] hazard_cnt,
  output logic [CNT_W-1:0] mem_stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [15:0] TimeoutVal = 16'(MEM_TIMEOUT);

  typedef enum logic [0:0] {StRun, StMemWait} state_e;

  state_e      state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        timeout_q, timeout_d;
  logic        mem_stall;

  // In StMemWait the access is still outstanding, so only mem_ready matters.
  assign mem_stall = (state_q == StRun) ? (mem_req & ~mem_ready) : ~mem_ready;

  // Next-state, wait counter, timeout flag and prioritised control outputs.
  always_comb begin
    freeze_IF  = 1'b0;
    flush_IF   = 1'b0;
    flush_ID   = 1'b0;
    freeze_all = 1'b0;
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;

    if (rst) begin
      state_d    = StRun;
      wait_cnt_d = '0;
      timeout_d  = 1'b0;
    end else begin
      if (mem_stall) begin
        freeze_all = 1'b1;
        freeze_IF  = 1'b1;
        state_d    = StMemWait;
        if (state_q == StRun) begin
          wait_cnt_d = '0;
        end else if (wait_cnt_q < TimeoutVal) begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end else begin
        state_d = StRun;
        if (branch_taken) begin
          flush_IF = 1'b1;
          flush_ID = 1'b1;
        end else if (hazard_Detected) begin
          freeze_IF = 1'b1;
          flush_ID  = 1'b1;
        end
      end
      if ((state_q == StMemWait) && (wait_cnt_q == TimeoutVal)) begin
        timeout_d = 1'b1;
      end
    end
  end

  // State, wait counter and sticky timeout registers.
  always_ff @(posedge clk) begin
    state_q    <= state_d;
    wait_cnt_q <= wait_cnt_d;
    timeout_q  <= timeout_d;
  end

  assign mem_timeout = timeout_q;

`ifdef STALL_PERF_CNT_EN
  logic [CNT_W-1:0] hazard_cnt_q, mem_stall_cnt_q, flush_cnt_q;
  logic             hazard_hit;

  // A load-use stall is the only case with freeze_IF but no freeze_all.
  assign hazard_hit = freeze_IF & ~freeze_all;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      hazard_cnt_q    <= '0;
      mem_stall_cnt_q <= '0;
      flush_cnt_q     <= '0;
    end else begin
      if (hazard_hit && !(&hazard_cnt_q))      hazard_cnt_q    <= hazard_cnt_q + 1'b1;
      if (freeze_all && !(&mem_stall_cnt_q))   mem_stall_cnt_q <= mem_stall_cnt_q + 1'b1;
      if (flush_IF && !(&flush_cnt_q))         flush_cnt_q     <= flush_cnt_q + 1'b1;
    end
  end

  assign hazard_cnt    = hazard_cnt_q;
  assign mem_stall_cnt = mem_stall_cnt_q;
  assign flush_cnt     = flush_cnt_q;
`else
  assign hazard_cnt    = '0;
  assign mem_stall_cnt = '0;
  assign flush_cnt     = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: vector table plus a counter saturation
// sequence, with expected records queued at drive time and popped at sampling.
module tb_pipeline_stall_controller;

  localparam int unsigned CntW   = 4;
  localparam int          CntMax = 15;
`ifdef STALL_PERF_CNT_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic            clk, rst, hazard_Detected, branch_taken, mem_req, mem_ready;
  logic            freeze_IF, flush_IF, flush_ID, freeze_all, mem_timeout;
  logic [CntW-1:0] hazard_cnt, mem_stall_cnt, flush_cnt;

  pipeline_stall_controller #(
    .MEM_TIMEOUT (4),
    .CNT_W       (CntW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .hazard_Detected (hazard_Detected),
    .branch_taken    (branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .freeze_IF       (freeze_IF),
    .flush_IF        (flush_IF),
    .flush_ID        (flush_ID),
    .freeze_all      (freeze_all),
    .mem_timeout     (mem_timeout),
    .hazard_cnt      (hazard_cnt),
    .mem_stall_cnt   (mem_stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rst, haz, br, req, rdy;
    logic f_if, fl_if, fl_id, f_all, to;
  } vec_t;

  vec_t sb_q[$];
  vec_t vecs[26];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_haz = 0, m_stall = 0, m_flush = 0;

  function automatic vec_t mk(input logic r, input logic h, input logic b, input logic q,
                              input logic y, input logic fif, input logic flif,
                              input logic flid, input logic fall, input logic t);
    vec_t v;
    v.rst = r; v.haz = h; v.br = b; v.req = q; v.rdy = y;
    v.f_if = fif; v.fl_if = flif; v.fl_id = flid; v.f_all = fall; v.to = t;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    vec_t e;
    rst             = v.rst;
    hazard_Detected = v.haz;
    branch_taken    = v.br;
    mem_req         = v.req;
    mem_ready       = v.rdy;
    sb_q.push_back(v);
    @(negedge clk);
    e = sb_q.pop_front();
    chk({tag, " freeze_IF"},     int'(freeze_IF),     int'(e.f_if));
    chk({tag, " flush_IF"},      int'(flush_IF),      int'(e.fl_if));
    chk({tag, " flush_ID"},      int'(flush_ID),      int'(e.fl_id));
    chk({tag, " freeze_all"},    int'(freeze_all),    int'(e.f_all));
    chk({tag, " mem_timeout"},   int'(mem_timeout),   int'(e.to));
    chk({tag, " hazard_cnt"},    int'(hazard_cnt),    PerfEn ? m_haz : 0);
    chk({tag, " mem_stall_cnt"}, int'(mem_stall_cnt), PerfEn ? m_stall : 0);
    chk({tag, " flush_cnt"},     int'(flush_cnt),     PerfEn ? m_flush : 0);
    // Advance the counter model with what this cycle is expected to produce.
    if (e.rst) begin
      m_haz = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (e.f_if && !e.f_all && m_haz < CntMax) m_haz++;
      if (e.f_all && m_stall < CntMax)          m_stall++;
      if (e.fl_if && m_flush < CntMax)          m_flush++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    //              rst haz br req rdy  fIF flIF flID fAll to
    vecs[0]  = mk(1, 1, 1, 1, 0,  0, 0, 0, 0, 0);  // reset forces outputs low
    vecs[1]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0);  // idle
    vecs[2]  = mk(0, 1, 0, 0, 0,  1, 0, 1, 0, 0);  // load-use stall
    vecs[3]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0);  // stall lasts one cycle
    vecs[4]  = mk(0, 1, 1, 0, 0,  0, 1, 1, 0, 0);  // branch beats hazard
    vecs[5]  = mk(0, 0, 0, 1, 1,  0, 0, 0, 0, 0);  // single-cycle access
    vecs[6]  = mk(0, 0, 0, 1, 0,  1, 0, 0, 1, 0);  // enter wait
    vecs[7]  = mk(0, 1, 1, 0, 0,  1, 0, 0, 1, 0);  // branch/hazard ignored in wait
    vecs[8]  = mk(0, 0, 0, 1, 0,  1, 0, 0, 1, 0);
    vecs[9]  = mk(0, 0, 0, 0, 1,  0, 0, 0, 0, 0);  // ready cycle releases
    vecs[10] = mk(0, 0, 0, 1, 0,  1, 0, 0, 1, 0);
    vecs[11] = mk(0, 0, 1, 0, 1,  0, 1, 1, 0, 0);  // ready + branch -> flush
    vecs[12] = mk(0, 0, 0, 1, 0,  1, 0, 0, 1, 0);
    vecs[13] = mk(0, 1, 0, 0, 1,  1, 0, 1, 0, 0);  // ready + hazard -> stall
    vecs[14] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0);  // back in run
    vecs[15] = mk(0, 0, 0, 1, 0,  1, 0, 0, 1, 0);  // timeout run: enter wait
    vecs[16] = mk(0, 0, 0, 0, 0,  1, 0, 0, 1, 0);
    vecs[17] = mk(0, 0, 0, 0, 0,  1, 0, 0, 1, 0);
    vecs[18] = mk(0, 0, 0, 0, 0,  1, 0, 0, 1, 0);
    vecs[19] = mk(0, 0, 0, 0, 0,  1, 0, 0, 1, 0);
    vecs[20] = mk(0, 0, 0, 0, 0,  1, 0, 0, 1, 0);  // counter at limit
    vecs[21] = mk(0, 1, 1, 0, 0,  1, 0, 0, 1, 1);  // timeout set, still waiting
    vecs[22] = mk(1, 1, 1, 1, 0,  0, 0, 0, 0, 1);  // reset mid-wait
    vecs[23] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0);  // run, timeout cleared
    vecs[24] = mk(0, 0, 0, 1, 0,  1, 0, 0, 1, 0);  // short wait after reset
    vecs[25] = mk(0, 0, 0, 0, 1,  0, 0, 0, 0, 0);  // no timeout

    rst = 1'b1; hazard_Detected = 1'b0; branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 26; i++) step(vecs[i], $sformatf("vec%0d", i));

    // Continuous branches push flush_cnt past its saturation point.
    for (int i = 0; i < 18; i++) step(mk(0, 0, 1, 0, 0,  0, 1, 1, 0, 0), $sformatf("sat%0d", i));
    step(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0), "sat_end");

    // Back-to-back hazards each stall for their own cycle.
    step(mk(0, 1, 0, 0, 0,  1, 0, 1, 0, 0), "haz_a");
    step(mk(0, 1, 0, 0, 0,  1, 0, 1, 0, 0), "haz_b");
    step(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0), "haz_end");

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255, is the number of MEM_WAIT cycles after which mem_timeout is raised (range 1..65535).
REQ-002 Parameter CNT_W, default 16, is the width of each performance counter.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 hazard_Detected  input  1  load-use hazard from the hazard detection logic, valid in the current cycle.
REQ-006 branch_taken  input  1  branch resolved taken in EXE this cycle.
REQ-007 mem_req  input  1  MEM stage issues a data-memory read/write this cycle.
REQ-008 mem_ready  input  1  data memory completes the access this cycle.
REQ-009 freeze_IF  output  1  hold the PC and IF/ID register.
REQ-010 flush_IF  output  1  clear the IF/ID register to a NOP.
REQ-011 flush_ID  output  1  load a bubble into the ID/EXE register.
REQ-012 freeze_all  output  1  hold the PC and all pipeline registers.
REQ-013 mem_timeout  output  1  sticky error: memory wait exceeded MEM_TIMEOUT.
REQ-014 hazard_cnt, mem_stall_cnt, flush_cnt  output  CNT_W each  performance counters (see Configuration).

Function
REQ-015 The FSM SHALL have two states, RUN and MEM_WAIT; outputs are Mealy (state plus current inputs), with no added latency.
REQ-016 Priority SHALL be: memory stall > branch flush > load-use stall.
REQ-017 In RUN with mem_req=1 and mem_ready=0: freeze_all=1 and freeze_IF=1; flush_IF, flush_ID=0; next state MEM_WAIT.
REQ-018 In MEM_WAIT with mem_ready=0: freeze_all=1 and freeze_IF=1; flush_IF, flush_ID=0; branch_taken and hazard_Detected are ignored; remain in MEM_WAIT.
REQ-019 In MEM_WAIT with mem_ready=1: outputs are evaluated exactly as RUN with no memory stall, and the next state is RUN.
REQ-020 Without a memory stall, branch_taken=1: flush_IF=1, flush_ID=1, freeze_IF=0; hazard_Detected is ignored in the same cycle.
REQ-021 Without a memory stall or branch, hazard_Detected=1: freeze_IF=1, flush_ID=1, flush_IF=0, freeze_all=0 for that cycle only.
REQ-022 In RUN with mem_req=1 and mem_ready=1 (single-cycle access): no freeze; the state stays RUN.
REQ-023 A wait counter (16 bits) SHALL clear on entry to MEM_WAIT, increment each MEM_WAIT cycle with mem_ready=0, and saturate at MEM_TIMEOUT.
REQ-024 When the wait counter reaches MEM_TIMEOUT, mem_timeout SHALL be set on the next edge and stay set until rst; the FSM keeps waiting.
REQ-025 All outputs other than the counters and mem_timeout SHALL be combinational; freeze_all=1 implies freeze_IF=1; flush_IF=1 never coexists with freeze_IF=1.

Reset
REQ-026 While rst=1: state=RUN, wait counter=0, mem_timeout=0, all counters=0, and all control outputs forced to 0 regardless of inputs.
REQ-027 Reset asserted during MEM_WAIT SHALL return the FSM to RUN on the next edge; the pending access is abandoned.

Configuration
REQ-028 Macro STALL_PERF_CNT_EN defined: hazard_cnt increments on each cycle satisfying REQ-021, mem_stall_cnt on each cycle with freeze_all=1, and flush_cnt on each cycle with flush_IF=1; all three saturate at 2^CNT_W-1.
REQ-029 Macro STALL_PERF_CNT_EN undefined: the counters are not built and the three count outputs are tied to 0.

Verification
REQ-030 Reset, then idle inputs -> all outputs 0 and state RUN.
REQ-031 hazard_Detected=1 for 1 cycle -> freeze_IF=1 and flush_ID=1 for exactly 1 cycle; hazard_cnt=1 (macro on).
REQ-032 mem_req=1, mem_ready low for 3 cycles then high -> freeze_all=1 for 3 cycles, 0 in the ready cycle; mem_stall_cnt=3.
REQ-033 branch_taken=1 and hazard_Detected=1 together -> flush_IF=1, flush_ID=1, freeze_IF=0.
REQ-034 MEM_TIMEOUT=4, mem_ready held 0 -> mem_timeout rises after 4 wait cycles and stays 1 until rst; rst mid-wait -> RUN, outputs 0.
REQ-035 Macro off -> hazard_cnt, mem_stall_cnt and flush_cnt remain 0 under the stimuli of REQ-031 to REQ-033.
